// File: rtl/bcd_sv_ff.sv
// bcd_sv_ff: sequential binary-to-ASCII-decimal converter.
// Converts a 14-bit unsigned value into four ASCII decimal digits with a
// shift-and-add-3 (double-dabble) engine, one shift per clock. The operand
// saturates to 9999. The result is held with a done flag until the request
// is withdrawn.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   bin_in       14-bit unsigned operand, latched on the request-sampling edge
//   cross_ready  level request, held high until bcd_ready is seen
//   ascii_out    four ASCII digits, thousands in [31:24] down to units in [7:0]
//   bcd_ready    level, high while ascii_out holds a completed conversion
module bcd_sv_ff (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin_in,
  input  logic        cross_ready,
  output logic [31:0] ascii_out,
  output logic        bcd_ready
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [13:0] MaxVal   = 14'd9999;
  localparam logic [3:0]  LastIter = 4'd13;  // counter value during the 14th shift
  localparam logic [31:0] AsciiZeros = 32'h3030_3030;

  state_e      state_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [15:0] bcd_adj;

  // Add-3 correction on every BCD nibble that would overflow past 9 when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ascii_out <= AsciiZeros;
      bcd_ready <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cross_ready) begin
            bin_q   <= (bin_in > MaxVal) ? MaxVal : bin_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (!cross_ready) begin
            // Abort: outputs untouched, nothing reported.
            state_q <= StIdle;
          end else begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            cnt_q          <= cnt_q + 4'd1;
            if (cnt_q == LastIter) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (!cross_ready) begin
            bcd_ready <= 1'b0;
            state_q   <= StIdle;
          end else if (!bcd_ready) begin
            // First cycle in DONE publishes the digits; 8'h30 + d == {4'h3, d}.
            ascii_out <= {4'h3, bcd_q[15:12], 4'h3, bcd_q[11:8],
                          4'h3, bcd_q[7:4],   4'h3, bcd_q[3:0]};
            bcd_ready <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sv_ff.sv
// Self-checking bench for bcd_sv_ff: directed boundary cases plus randomized
// conversions checked against an arithmetic decimal-formatting model.
module tb_bcd_sv_ff;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic        cross_ready;
  logic [31:0] ascii_out;
  logic        bcd_ready;

  int n_cmp;
  int n_err;

  bcd_sv_ff dut (
    .clk         (clk),
    .rst         (rst),
    .bin_in      (bin_in),
    .cross_ready (cross_ready),
    .ascii_out   (ascii_out),
    .bcd_ready   (bcd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: saturate to 9999, then format as four decimal ASCII digits.
  function automatic logic [31:0] model(input int unsigned x);
    int unsigned v;
    v = (x > 9999) ? 9999 : x;
    return {8'h30 + 8'(v / 1000), 8'h30 + 8'((v / 100) % 10),
            8'h30 + 8'((v / 10) % 10), 8'h30 + 8'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: request, wait for done, hold, release.
  task automatic run_conv(input int unsigned val, input int hold_cycles, input bit scramble);
    logic [31:0] exp;
    int          lat;
    bit          held_ok;
    exp         = model(val);
    bin_in      = 14'(val);
    cross_ready = 1'b1;
    tick();  // request-sampling edge
    if (scramble) bin_in = 14'd8888;
    lat = 0;
    while (!bcd_ready && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'd15);
    check_eq("ascii", ascii_out, exp);
    held_ok = 1'b1;
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      if (bcd_ready !== 1'b1 || ascii_out !== exp) held_ok = 1'b0;
    end
    check_eq("hold", 32'(held_ok), 32'd1);
    cross_ready = 1'b0;
    tick();
    check_eq("ready_fall", 32'(bcd_ready), 32'd0);
    check_eq("ascii_kept", ascii_out, exp);
    tick();  // one idle edge before any new request
  endtask

  initial begin
    logic [31:0] prev;
    bit          quiet;
    int unsigned v;
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    bin_in      = '0;
    cross_ready = 1'b0;
    #12;
    check_eq("rst_ascii", ascii_out, 32'h3030_3030);
    check_eq("rst_ready", 32'(bcd_ready), 32'd0);
    rst = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bcd_ready !== 1'b0 || ascii_out !== 32'h3030_3030) quiet = 1'b0;
    end
    check_eq("idle_quiet", 32'(quiet), 32'd1);

    run_conv(1234, 0, 1'b0);
    check_eq("ascii_1234", ascii_out, 32'h3132_3334);
    run_conv(0, 1, 1'b0);
    check_eq("ascii_0", ascii_out, 32'h3030_3030);
    run_conv(9999, 1, 1'b0);
    check_eq("ascii_9999", ascii_out, 32'h3939_3939);
    run_conv(255, 1, 1'b0);
    check_eq("ascii_255", ascii_out, 32'h3032_3535);
    run_conv(12000, 1, 1'b0);
    check_eq("sat_12000", ascii_out, 32'h3939_3939);
    run_conv(16383, 1, 1'b0);
    check_eq("sat_16383", ascii_out, 32'h3939_3939);
    run_conv(7, 0, 1'b0);

    // Abort mid-shift.
    prev        = ascii_out;
    bin_in      = 14'd4321;
    cross_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    cross_ready = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bcd_ready !== 1'b0 || ascii_out !== prev) quiet = 1'b0;
    end
    check_eq("abort_quiet", 32'(quiet), 32'd1);
    run_conv(4321, 0, 1'b0);
    check_eq("ascii_4321", ascii_out, 32'h3433_3231);

    // Operand changes after the latch edge are ignored; long hold.
    run_conv(56, 10, 1'b1);
    check_eq("ascii_56", ascii_out, 32'h3030_3536);

    // Reset mid-conversion.
    bin_in      = 14'd999;
    cross_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_ascii", ascii_out, 32'h3030_3030);
    check_eq("midrst_ready", 32'(bcd_ready), 32'd0);
    cross_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bcd_ready !== 1'b0) quiet = 1'b0;
    end
    check_eq("midrst_quiet", 32'(quiet), 32'd1);

    // Randomized conversions, biased toward the saturation boundary.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(9990, 10010);
        1:       v = $urandom_range(0, 255);
        default: v = $urandom_range(0, 16383);
      endcase
      run_conv(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
